seg_display_decoder: RTL
========================

Name: seg_display_decoder

Overview:
- Passive monitor on the multiplexed 7-segment bus driven by clock_top (o_Segments/o_Digits). It reverse-decodes the bus into four BCD digits plus dot flags.
- Samples each digit slot after a settle window, decodes segment patterns, and assembles full frames. A frame is published only after it repeats unchanged for a set number of scans.
- Used as a self-checking readback for integration benches and as the source for a future UART time-report path.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit slots. The block is only defined for 4.
- SETTLE_CYCLES, 4, consecutive cycles a one-hot digit select must hold before the segments are sampled (1..255).
- STABLE_FRAMES, 2, consecutive identical frames required before publishing (1..15).
- TIMEOUT_CYCLES, 4096, cycles without any capture before o_Valid drops (16..2^20).

Ports:
- i_Clock  in  1  system clock
- i_Reset  in  1  synchronous active-high reset
- i_Segments  in  8  bus segments: bit7 dot, bits6:0 gfedcba, active-high
- i_Digits  in  4  digit enables, one-hot active-high: [3] hour tens, [2] hour units, [1] min tens, [0] min units
- o_Hour_Tens  out  4  published digit code
- o_Hour_Units  out  4  published digit code
- o_Min_Tens  out  4  published digit code
- o_Min_Units  out  4  published digit code
- o_Dots  out  4  published dot flags, same slot order as i_Digits
- o_Frame_Strobe  out  1  one-cycle pulse when new outputs are published
- o_Valid  out  1  published outputs are current
- o_Error  out  1  sticky; set by an illegal pattern or a multi-hot select

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high on i_Reset. Both inputs are registered once (1-cycle input latency).
- Reset values:
  - All digit outputs = 4'hF (BLANK).
  - o_Dots = 0, o_Frame_Strobe = 0, o_Valid = 0, o_Error = 0.
  - FSM = IDLE; settle counter, capture mask, stable counter and timeout counter all = 0.
- Decode (combinational, on the registered segments):
  - The 10 standard gfedcba patterns map to 0..9 (0=7'h3F, 1=7'h06, 2=7'h5B, 3=7'h4F, 4=7'h66, 5=7'h6D, 6=7'h7D, 7=7'h07, 8=7'h7F, 9=7'h6F).
  - 7'h00 maps to BLANK (4'hF). Any other pattern maps to INVALID (4'hE).
  - The dot is taken from bit7.
- Select classification (on the registered i_Digits):
  - 0000 = none.
  - Exactly one bit set = slot index.
  - More than one bit set = multi-hot.
- FSM states and transitions:
  - IDLE:
    - One-hot select -> SETTLE, counter = 1.
    - Multi-hot -> stay in IDLE, set o_Error.
  - SETTLE:
    - Same select -> counter +1.
    - When the counter reaches SETTLE_CYCLES, capture the decoded code and dot into slot[idx], set mask[idx], go to HELD.
    - Select changes to a different one-hot value -> restart SETTLE with counter = 1 and no capture.
    - Select goes to none -> IDLE.
    - Multi-hot -> IDLE, set o_Error.
  - HELD:
    - Same select -> stay; no further capture on this visit.
    - Different one-hot -> SETTLE.
    - None -> IDLE.
    - Multi-hot -> IDLE, set o_Error.
- INVALID capture:
  - Sets o_Error. The INVALID code is still stored in the slot.
- Revisiting a slot before the frame completes:
  - The new capture overwrites the old one (latest wins).
- Frame completion:
  - A frame completes when mask == 4'b1111 (including when the 4th capture happens in the current cycle).
  - On the next cycle:
    - Compare the frame with the previous candidate.
    - Equal -> stable counter +1, saturating at STABLE_FRAMES.
    - Not equal -> stable counter = 1 and the candidate is replaced.
    - Mask is cleared.
  - Publish when the stable counter reaches STABLE_FRAMES and the candidate differs from the outputs, or o_Valid == 0:
    - Outputs update in that cycle.
    - o_Frame_Strobe pulses 1 cycle.
    - o_Valid = 1.
  - A stable, unchanged frame produces no strobe.
  - With STABLE_FRAMES = 1, every frame that differs from the outputs publishes.
- Timeout:
  - The counter resets on every capture.
  - On reaching TIMEOUT_CYCLES: o_Valid = 0, mask cleared, stable counter = 0. Digit outputs hold their last values.
- Reset mid-frame:
  - Abandons partial captures. Outputs return to reset values on the next edge.
- Blinking (settings mode):
  - Blank slots decode as BLANK and are legal. A blinking display therefore alternates between frames and publishes only if it holds for STABLE_FRAMES scans.

Decomposition:
- Package seg_decode_pkg holds:
  - the ten segment pattern constants;
  - the BLANK and INVALID codes;
  - the slot index constants (HOUR_TENS=3 .. MIN_UNITS=0);
  - the FSM state enum (IDLE, SETTLE, HELD).
- One sub-module, seg7_to_bcd: combinational, 7-bit pattern in, 4-bit code out. It is unit-testable against the same package constants.

Test Plan:
1. Bus scans 1,2,3,4 (dot on slot 2), 8 cycles per slot, 3 scans, SETTLE=4, STABLE=2 -> o_Frame_Strobe once, at the end of scan 2. Outputs 1/2/3/4, o_Dots=0100, o_Valid=1, o_Error=0.
2. Select held only 3 cycles per slot with SETTLE=4 -> no captures, no strobe, o_Valid stays 0. After TIMEOUT_CYCLES, still 0.
3. Stable 12:34 published, then minute units change to 5 for 2 scans -> exactly one strobe; o_Min_Units=5; other slots unchanged.
4. Single-cycle glitch i_Digits=0101 mid-scan -> o_Error=1 (sticky), FSM to IDLE, partial frame discarded. The next two clean scans publish normally while o_Error remains 1.
5. Slot 0 shows 7'h00 on alternating scans (blink) -> no publish while alternating. Holding blank for 2 scans publishes o_Min_Units=4'hF.
6. Published and valid, then i_Digits=0000 for TIMEOUT_CYCLES -> o_Valid=0 with digits held. Assert i_Reset for 1 cycle during the 3rd slot capture -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/seg_decode_pkg.sv
// ---------------------------------------------------------------------------
// seg_decode_pkg
// Shared constants for reverse-decoding the multiplexed 7-segment bus:
//   - gfedcba patterns for the ten decimal digits (active-high segments)
//   - BLANK / INVALID digit codes
//   - digit slot indices matching the bit order of the digit-select bus
//   - state encoding for the slot-sampling FSM
// ---------------------------------------------------------------------------
package seg_decode_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] CODE_BLANK   = 4'hF;
    localparam logic [3:0] CODE_INVALID = 4'hE;

    localparam int HOUR_TENS  = 3;
    localparam int HOUR_UNITS = 2;
    localparam int MIN_TENS   = 1;
    localparam int MIN_UNITS  = 0;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD
    } state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// ---------------------------------------------------------------------------
// seg7_to_bcd
// Combinational decode of one 7-segment pattern back into a digit code.
// Ports:
//   i_Pattern  in  7  segment pattern, gfedcba, active-high
//   o_Code     out 4  0..9 for a legal digit, BLANK for all-off, else INVALID
// ---------------------------------------------------------------------------
module seg7_to_bcd
    import seg_decode_pkg::*;
(
    input  logic [6:0] i_Pattern,
    output logic [3:0] o_Code
);

    always_comb begin
        case (i_Pattern)
            SEG_0:     o_Code = 4'd0;
            SEG_1:     o_Code = 4'd1;
            SEG_2:     o_Code = 4'd2;
            SEG_3:     o_Code = 4'd3;
            SEG_4:     o_Code = 4'd4;
            SEG_5:     o_Code = 4'd5;
            SEG_6:     o_Code = 4'd6;
            SEG_7:     o_Code = 4'd7;
            SEG_8:     o_Code = 4'd8;
            SEG_9:     o_Code = 4'd9;
            SEG_BLANK: o_Code = CODE_BLANK;
            default:   o_Code = CODE_INVALID;
        endcase
    end

endmodule

// File: rtl/seg_display_decoder.sv
// ---------------------------------------------------------------------------
// seg_display_decoder
// Passive monitor of a multiplexed 7-segment bus. Each digit slot is sampled
// once its select has been steady for SETTLE_CYCLES, four captures form a
// frame, and a frame is published once it has repeated STABLE_FRAMES times.
// Ports:
//   i_Clock         in  1  system clock
//   i_Reset         in  1  synchronous active-high reset
//   i_Segments      in  8  bit7 dot, bits6:0 gfedcba, active-high
//   i_Digits        in  4  one-hot slot select ([3] hour tens .. [0] min units)
//   o_Hour_Tens     out 4  published digit codes
//   o_Hour_Units    out 4
//   o_Min_Tens      out 4
//   o_Min_Units     out 4
//   o_Dots          out 4  published dot flags, same slot order as i_Digits
//   o_Frame_Strobe  out 1  one-cycle pulse on each publish
//   o_Valid         out 1  published outputs are current
//   o_Error         out 1  sticky: illegal pattern captured or multi-hot select
// ---------------------------------------------------------------------------
module seg_display_decoder
    import seg_decode_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int STABLE_FRAMES  = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic [7:0] i_Segments,
    input  logic [3:0] i_Digits,
    output logic [3:0] o_Hour_Tens,
    output logic [3:0] o_Hour_Units,
    output logic [3:0] o_Min_Tens,
    output logic [3:0] o_Min_Units,
    output logic [3:0] o_Dots,
    output logic       o_Frame_Strobe,
    output logic       o_Valid,
    output logic       o_Error
);

    localparam int                TO_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam int                FRAME_W     = NUM_DIGITS * 5;
    localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0]        STABLE_MAX  = 4'(STABLE_FRAMES);
    localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_MAX      = TO_W'(TIMEOUT_CYCLES);

    logic [7:0]                   r_seg;
    logic [3:0]                   r_dig;
    state_t                       r_state;
    logic [3:0]                   r_sel;
    logic [7:0]                   r_settleCnt;
    logic [NUM_DIGITS-1:0][3:0]   r_slotCode;
    logic [NUM_DIGITS-1:0]        r_slotDot;
    logic [NUM_DIGITS-1:0]        r_mask;
    logic [FRAME_W-1:0]           r_cand;
    logic [3:0]                   r_stable;
    logic [TO_W-1:0]              r_timeoutCnt;
    logic [NUM_DIGITS-1:0][3:0]   r_pubCode;
    logic [NUM_DIGITS-1:0]        r_pubDots;
    logic                         r_strobe;
    logic                         r_valid;
    logic                         r_error;

    logic [3:0]                   w_code;
    logic                         w_selNone;
    logic                         w_selOneHot;
    logic                         w_selMulti;
    logic [1:0]                   w_selIdx;
    logic                         w_newSel;
    state_t                       w_stateNext;
    logic [3:0]                   w_selNext;
    logic [7:0]                   w_settleNext;
    logic                         w_capture;
    logic                         w_errorSet;
    logic [NUM_DIGITS-1:0]        w_capBit;
    logic [NUM_DIGITS-1:0]        w_maskNext;
    logic                         w_frameDone;
    logic [FRAME_W-1:0]           w_frame;
    logic [3:0]                   w_stableNext;
    logic                         w_publish;
    logic                         w_timeout;

    // Bus inputs are registered once before any decoding.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_seg <= '0;
            r_dig <= '0;
        end else begin
            r_seg <= i_Segments;
            r_dig <= i_Digits;
        end
    end

    seg7_to_bcd u_decode (
        .i_Pattern (r_seg[6:0]),
        .o_Code    (w_code)
    );

    always_comb begin
        w_selNone   = (r_dig == 4'b0000);
        w_selOneHot = $onehot(r_dig);
        w_selMulti  = !w_selNone && !w_selOneHot;
        case (r_dig)
            4'b0010: w_selIdx = 2'd1;
            4'b0100: w_selIdx = 2'd2;
            4'b1000: w_selIdx = 2'd3;
            default: w_selIdx = 2'd0;
        endcase
    end

    // A select counts as new when coming out of IDLE or when it moved to a
    // different slot; either way the settle window starts over.
    assign w_newSel = w_selOneHot && ((r_state == IDLE) || (r_dig != r_sel));

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state     <= IDLE;
            r_sel       <= '0;
            r_settleCnt <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_sel       <= w_selNext;
            r_settleCnt <= w_settleNext;
        end
    end

    // The entry cycle counts as settle cycle 1, so the capture fires in the
    // SETTLE_CYCLES-th consecutive cycle of the same select.
    always_comb begin
        w_stateNext  = r_state;
        w_selNext    = r_sel;
        w_settleNext = r_settleCnt;
        if (w_selMulti || w_selNone) begin
            w_stateNext  = IDLE;
            w_settleNext = '0;
        end else if (w_newSel) begin
            w_selNext    = r_dig;
            w_settleNext = 8'd1;
            w_stateNext  = (SETTLE_CYCLES == 1) ? HELD : SETTLE;
        end else if (r_state == SETTLE) begin
            if (r_settleCnt == SETTLE_LAST) begin
                w_stateNext = HELD;
            end else begin
                w_settleNext = r_settleCnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_capture = 1'b0;
        if (w_newSel) begin
            w_capture = (SETTLE_CYCLES == 1);
        end else if ((r_state == SETTLE) && w_selOneHot && (r_settleCnt == SETTLE_LAST)) begin
            w_capture = 1'b1;
        end
        w_errorSet = w_selMulti || (w_capture && (w_code == CODE_INVALID));
    end

    // A full mask is consumed in the cycle after it fills; a capture landing
    // in that same cycle already starts the next frame.
    always_comb begin
        w_capBit = '0;
        if (w_capture) begin
            w_capBit[w_selIdx] = 1'b1;
        end
        w_frameDone = &r_mask;
        w_maskNext  = (w_frameDone ? '0 : r_mask) | w_capBit;
        w_frame     = {r_slotCode, r_slotDot};
        if (w_frame == r_cand) begin
            w_stableNext = (r_stable >= STABLE_MAX) ? STABLE_MAX : r_stable + 4'd1;
        end else begin
            w_stableNext = 4'd1;
        end
        w_publish = w_frameDone && (w_stableNext == STABLE_MAX)
                    && ((w_frame != {r_pubCode, r_pubDots}) || !r_valid);
        w_timeout = !w_capture && (r_timeoutCnt == TO_LAST);
    end

    // Capture slots, frame assembly, stability tracking and publishing.
    // A timeout invalidates the outputs but leaves the digit codes in place.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_slotCode   <= {NUM_DIGITS{CODE_BLANK}};
            r_slotDot    <= '0;
            r_mask       <= '0;
            r_cand       <= '0;
            r_stable     <= '0;
            r_timeoutCnt <= '0;
            r_pubCode    <= {NUM_DIGITS{CODE_BLANK}};
            r_pubDots    <= '0;
            r_strobe     <= 1'b0;
            r_valid      <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_strobe <= w_publish && !w_timeout;

            if (w_capture) begin
                r_slotCode[w_selIdx] <= w_code;
                r_slotDot[w_selIdx]  <= r_seg[7];
                r_timeoutCnt         <= '0;
            end else if (r_timeoutCnt != TO_MAX) begin
                r_timeoutCnt <= r_timeoutCnt + 1'b1;
            end

            if (w_timeout || w_selMulti) begin
                r_mask <= '0;
            end else begin
                r_mask <= w_maskNext;
            end

            if (w_timeout) begin
                r_stable <= '0;
                r_valid  <= 1'b0;
            end else if (w_frameDone) begin
                r_cand   <= w_frame;
                r_stable <= w_stableNext;
                if (w_publish) begin
                    r_pubCode <= r_slotCode;
                    r_pubDots <= r_slotDot;
                    r_valid   <= 1'b1;
                end
            end

            if (w_errorSet) begin
                r_error <= 1'b1;
            end
        end
    end

    assign o_Hour_Tens    = r_pubCode[HOUR_TENS];
    assign o_Hour_Units   = r_pubCode[HOUR_UNITS];
    assign o_Min_Tens     = r_pubCode[MIN_TENS];
    assign o_Min_Units    = r_pubCode[MIN_UNITS];
    assign o_Dots         = r_pubDots;
    assign o_Frame_Strobe = r_strobe;
    assign o_Valid        = r_valid;
    assign o_Error        = r_error;

endmodule
